// File: rtl/cfir_pkg.sv
// cfir_pkg: shared constants for the compensating FIR ahead of the CIC
// interpolator.
//   - default widths: CFIR_WIN, CFIR_WC, CFIR_WOUT, CFIR_NTAPS, CFIR_WACC
//   - cfir_coef(): the fixed Q1.15 droop-compensation taps; c[k] multiplies x[n-k]
//   - cfir_state_t: FSM encoding shared by the top level
package cfir_pkg;

  localparam int CFIR_WIN   = 16;
  localparam int CFIR_WC    = 16;
  localparam int CFIR_WOUT  = 16;
  localparam int CFIR_NTAPS = 7;
  localparam int CFIR_WACC  = CFIR_WIN + CFIR_WC + $clog2(CFIR_NTAPS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } cfir_state_t;

  // Symmetric taps. Their sum is 18350, so the DC gain is 18350/32768.
  // The inverse-sinc peak lifts the CIC passband edge.
  function automatic logic signed [CFIR_WC-1:0] cfir_coef(input int idx);
    case (idx)
      0, 6:    cfir_coef = -16'sd655;
      1, 5:    cfir_coef = 16'sd2621;
      2, 4:    cfir_coef = -16'sd5898;
      3:       cfir_coef = 16'sd26214;
      default: cfir_coef = '0;
    endcase
  endfunction

endpackage

// File: rtl/cfir_comp_mac.sv
// cfir_comp_mac: signed multiply-accumulate, one product per enabled cycle.
// Ports:
//   clk, rst   clock, async active-low reset
//   clr        zero the accumulator; takes priority over en
//   en         add coef*x into the accumulator this cycle
//   coef, x    signed operands (Q1.15 each)
//   acc        full-precision signed running sum
module cfir_comp_mac
  import cfir_pkg::*;
#(
  parameter int WIN  = CFIR_WIN,
  parameter int WC   = CFIR_WC,
  parameter int WACC = CFIR_WACC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [WC-1:0]   coef,
  input  logic signed [WIN-1:0]  x,
  output logic signed [WACC-1:0] acc
);

  localparam int WP = WIN + WC;

  logic signed [WP-1:0]   prod;
  logic signed [WACC-1:0] prod_ext;

  assign prod     = coef * x;
  // Growth bits above the product absorb the sum of NTAPS products.
  assign prod_ext = {{(WACC-WP){prod[WP-1]}}, prod};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + prod_ext;
  end

endmodule

// File: rtl/cfir_comp.sv
// cfir_comp: compensating FIR in front of the CIC interpolator. One output
// sample per accepted input; a single MAC walks the NTAPS taps per sample.
// Build option: define CFIR_SAT_EN to saturate o_data instead of wrapping.
// Ports:
//   clk, rst   clock, async active-low reset
//   i_data     signed input sample, qualified by val_in
//   val_in     one-cycle strobe; ignored while busy
//   o_data     signed filtered sample, held between strobes
//   val_out    one-cycle strobe, o_data updated
//   busy       high from acceptance until the result is handed off
// Timing: accept at edge E0, taps at E1..E(NTAPS), hand-off edge, then
// o_data/val_out one edge later (NTAPS+2 edges after E0). busy drops at the
// hand-off edge, so a new sample can be accepted while val_out is presented.
module cfir_comp
  import cfir_pkg::*;
#(
  parameter int WIN   = CFIR_WIN,
  parameter int WC    = CFIR_WC,
  parameter int WOUT  = CFIR_WOUT,
  parameter int NTAPS = CFIR_NTAPS,
  parameter int WACC  = CFIR_WACC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [WIN-1:0]  i_data,
  input  logic                   val_in,
  output logic signed [WOUT-1:0] o_data,
  output logic                   val_out,
  output logic                   busy
);

  localparam int TAP_W = $clog2(NTAPS);
  localparam int LSB   = WIN + WC - 2 - (WOUT - 1);
  localparam int MSB   = WIN + WC - 2;

  cfir_state_t                   state;
  logic [TAP_W-1:0]              tap;
  logic [NTAPS-1:0][WIN-1:0]     dly;
  logic                          out_pend;
  logic                          mac_clr;
  logic                          mac_en;
  logic signed [WACC-1:0]        acc;
  logic signed [WOUT-1:0]        res;

  assign mac_clr = (state == ST_IDLE) && val_in;
  assign mac_en  = (state == ST_MAC);

  cfir_comp_mac #(.WIN(WIN), .WC(WC), .WACC(WACC)) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr  (mac_clr),
    .en   (mac_en),
    .coef (cfir_coef(int'(tap))),
    .x    (dly[tap]),
    .acc  (acc)
  );

  // Output slice: Q-format realignment by floor truncation.
`ifdef CFIR_SAT_EN
  logic [WACC-1:MSB] acc_hi;
  assign acc_hi = acc[WACC-1:MSB];
  always_comb begin
    res = acc[MSB:LSB];
    // Guard bits disagree -> value does not fit WOUT; clamp by sign.
    if (!((&acc_hi) || !(|acc_hi)))
      res = acc[WACC-1] ? {1'b1, {(WOUT-1){1'b0}}} : {1'b0, {(WOUT-1){1'b1}}};
  end
`else
  assign res = acc[MSB:LSB];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      tap      <= '0;
      dly      <= '0;
      busy     <= 1'b0;
      out_pend <= 1'b0;
    end else begin
      out_pend <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (val_in) begin
            dly   <= {dly[NTAPS-2:0], i_data};
            tap   <= '0;
            busy  <= 1'b1;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (tap == TAP_W'(NTAPS-1)) state <= ST_OUT;
          else                        tap   <= tap + 1'b1;
        end
        ST_OUT: begin
          // acc is final and stays put until the next acceptance clears it,
          // which cannot happen before the output register samples it.
          busy     <= 1'b0;
          out_pend <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_data  <= '0;
      val_out <= 1'b0;
    end else begin
      val_out <= out_pend;
      if (out_pend) o_data <= res;
    end
  end

endmodule
